// File: rtl/softmax_mem_responder.sv
// Vector store and job sequencer on the memory side of the softmax block.
// Loads host vectors into a local buffer, kicks off softmax, serves its three
// combinational read ports and reports completion or timeout to the host.
module softmax_mem_responder #(
   parameter int unsigned DATAWIDTH = 16,
   parameter int unsigned NUM       = 4,
   parameter int unsigned ADDRSIZE  = 8,
   parameter int unsigned TIMEOUT   = 4096
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [DATAWIDTH*NUM-1:0] wr_data,
   input  logic                     wr_last,
   input  logic [ADDRSIZE-1:0]      base_addr,
   output logic                     init,
   output logic                     start,
   output logic [ADDRSIZE-1:0]      start_addr,
   output logic [ADDRSIZE-1:0]      end_addr,
   input  logic [ADDRSIZE-1:0]      addr,
   input  logic [ADDRSIZE-1:0]      sub0_inp_addr,
   input  logic [ADDRSIZE-1:0]      sub1_inp_addr,
   output logic [DATAWIDTH*NUM-1:0] inp,
   output logic [DATAWIDTH*NUM-1:0] sub0_inp,
   output logic [DATAWIDTH*NUM-1:0] sub1_inp,
   input  logic                     sm_done,
   output logic                     busy,
   output logic                     job_done,
   output logic                     err
);

   localparam int unsigned Depth = 2 ** ADDRSIZE;
   localparam int unsigned CntW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   // Last address a word may land on, so that end_addr (one past it) never wraps.
   localparam logic [ADDRSIZE-1:0] LastAddr = {{(ADDRSIZE-1){1'b1}}, 1'b0};

   typedef enum logic [2:0] {StIdle, StLoad, StInit, StStart, StWait, StFin} state_e;

   state_e                state_q, state_d;
   logic [ADDRSIZE-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDRSIZE-1:0]   base_q, base_d;
   logic [ADDRSIZE-1:0]   start_addr_q, start_addr_d;
   logic [ADDRSIZE-1:0]   end_addr_q, end_addr_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  err_q, err_d;
   logic                  sm_done_q;
   logic                  wr_ready_q, init_q, start_q, busy_q, job_done_q;
   logic                  accept, mem_we, at_limit, done_rise;
   logic [ADDRSIZE-1:0]   wr_addr;

   logic [DATAWIDTH*NUM-1:0] mem [Depth];

   assign accept    = wr_valid & wr_ready_q;
   assign wr_addr   = (state_q == StIdle) ? base_addr : wr_ptr_q;
   assign at_limit  = (wr_addr == LastAddr);
   assign done_rise = sm_done & ~sm_done_q;

   // Next-state, pointer, address and error bookkeeping.
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      base_d       = base_q;
      start_addr_d = start_addr_q;
      end_addr_d   = end_addr_q;
      cnt_d        = cnt_q;
      err_d        = err_q;
      mem_we       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               mem_we   = 1'b1;
               base_d   = base_addr;
               wr_ptr_d = base_addr + 1'b1;
               err_d    = at_limit;
               if (wr_last || at_limit) begin
                  state_d      = StInit;
                  start_addr_d = base_addr;
                  end_addr_d   = wr_ptr_d;
               end else begin
                  state_d = StLoad;
               end
            end
         end
         StLoad: begin
            if (accept) begin
               mem_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + 1'b1;
               if (at_limit) err_d = 1'b1;
               if (wr_last || at_limit) begin
                  state_d      = StInit;
                  start_addr_d = base_q;
                  end_addr_d   = wr_ptr_d;
               end
            end
         end
         StInit: state_d = StStart;
         StStart: begin
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            // A level already high on entry never produces done_rise here.
            if (done_rise) begin
               state_d = StFin;
            end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = StFin;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StFin: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State and registered outputs; outputs decode the next state so they
   // line up with the state register yet stay low throughout reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         wr_ptr_q     <= '0;
         base_q       <= '0;
         start_addr_q <= '0;
         end_addr_q   <= '0;
         cnt_q        <= '0;
         err_q        <= 1'b0;
         sm_done_q    <= 1'b0;
         wr_ready_q   <= 1'b0;
         init_q       <= 1'b0;
         start_q      <= 1'b0;
         busy_q       <= 1'b0;
         job_done_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         base_q       <= base_d;
         start_addr_q <= start_addr_d;
         end_addr_q   <= end_addr_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
         sm_done_q    <= sm_done;
         wr_ready_q   <= (state_d == StIdle) || (state_d == StLoad);
         init_q       <= (state_d == StInit);
         start_q      <= (state_d == StStart);
         busy_q       <= (state_d != StIdle);
         job_done_q   <= (state_d == StFin);
      end
   end

   // Buffer write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) mem[wr_addr] <= wr_data;
   end

   // Zero-latency reads; a same-cycle write is not visible until the next cycle.
   assign inp        = mem[addr];
   assign sub0_inp   = mem[sub0_inp_addr];
   assign sub1_inp   = mem[sub1_inp_addr];

   assign wr_ready   = wr_ready_q;
   assign init       = init_q;
   assign start      = start_q;
   assign start_addr = start_addr_q;
   assign end_addr   = end_addr_q;
   assign busy       = busy_q;
   assign job_done   = job_done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_softmax_mem_responder.sv
// Self-checking bench: directed job table, hand-written corner sequences and
// randomized jobs checked against a job-level buffer model.
module tb_softmax_mem_responder;

   localparam int unsigned Timeout = 64;

   logic        clk = 1'b0;
   logic        reset, wr_valid, wr_last, sm_done;
   logic [63:0] wr_data;
   logic [7:0]  base_addr, addr, sub0_inp_addr, sub1_inp_addr;
   logic        wr_ready, init, start, busy, job_done, err;
   logic [7:0]  start_addr, end_addr;
   logic [63:0] inp, sub0_inp, sub1_inp;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference buffer contents: what the host has successfully written.
   logic [63:0] mmem [256];
   bit          mval [256];

   typedef struct {
      logic [7:0] base;
      int         n;
      bit         has_last;
      bit         gaps;
      logic [7:0] exp_end;
      bit         exp_err;
      int         dly;
   } vec_t;
   vec_t vecs [6];

   softmax_mem_responder #(
      .DATAWIDTH(16), .NUM(4), .ADDRSIZE(8), .TIMEOUT(Timeout)
   ) dut (
      .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_data(wr_data), .wr_last(wr_last), .base_addr(base_addr), .init(init),
      .start(start), .start_addr(start_addr), .end_addr(end_addr), .addr(addr),
      .sub0_inp_addr(sub0_inp_addr), .sub1_inp_addr(sub1_inp_addr), .inp(inp),
      .sub0_inp(sub0_inp), .sub1_inp(sub1_inp), .sm_done(sm_done), .busy(busy),
      .job_done(job_done), .err(err)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, got %0d failures so far", n_fail);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      check(name, 64'(act), 64'(exp));
   endtask

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   // Words accepted for a job: consecutive addresses from base, stopping at
   // the host's last word or at address 254 (which also flags an error).
   function automatic int load_len(input logic [7:0] base, input int n, output bit ovf);
      ovf = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (int'(base) + i == 254) begin
            ovf = 1'b1;
            return i + 1;
         end
      end
      return n;
   endfunction

   // Drives one job's words; returns in the START cycle.
   task automatic run_load(input logic [7:0] base, input int n, input bit has_last,
                           input bit gaps, input bit pat, input logic [7:0] exp_end,
                           input bit exp_err);
      int          cnt;
      bit          ovf;
      logic [63:0] d;
      logic [7:0]  a;
      cnt = load_len(base, n, ovf);
      for (int i = 0; i < cnt; i++) begin
         a = base + 8'(i);
         if (gaps && i > 0) begin
            wr_valid  = 1'b0;
            wr_data   = rand64();
            wr_last   = 1'b1;
            base_addr = 8'($urandom);
            tick();
            chk1("busy during gap", busy, 1'b1);
         end
         d = pat ? {16'(4 * i + 1), 16'(4 * i + 2), 16'(4 * i + 3), 16'(4 * i + 4)} : rand64();
         wr_valid  = 1'b1;
         wr_data   = d;
         wr_last   = has_last && (i == n - 1);
         base_addr = (i == 0) ? base : 8'($urandom);
         if (mval[a]) begin
            sub1_inp_addr = a;
            #1;
            check("old data on write collision", sub1_inp, mmem[a]);
         end
         chk1("wr_ready while loading", wr_ready, 1'b1);
         tick();
         mmem[a] = d;
         mval[a] = 1'b1;
      end
      // INIT cycle: offer another word, which must be refused.
      wr_valid = 1'b1;
      wr_data  = rand64();
      wr_last  = 1'b1;
      chk1("init pulse", init, 1'b1);
      chk1("start low in init", start, 1'b0);
      chk1("wr_ready low in init", wr_ready, 1'b0);
      chk1("busy in init", busy, 1'b1);
      check("start_addr", 64'(start_addr), 64'(base));
      check("end_addr", 64'(end_addr), 64'(exp_end));
      chk1("err after load", err, exp_err);
      tick();
      chk1("start pulse", start, 1'b1);
      chk1("init low in start", init, 1'b0);
      chk1("wr_ready low in start", wr_ready, 1'b0);
      wr_valid = 1'b0;
   endtask

   // One read per WAIT cycle, all three ports on different words.
   task automatic run_reads(input logic [7:0] base, input int cnt);
      for (int j = 0; j < cnt; j++) begin
         addr          = base + 8'(j);
         sub0_inp_addr = base + 8'((j + 1) % cnt);
         sub1_inp_addr = base + 8'(cnt - 1 - j);
         tick();
         check("inp read", inp, mmem[addr]);
         check("sub0 read", sub0_inp, mmem[sub0_inp_addr]);
         check("sub1 read", sub1_inp, mmem[sub1_inp_addr]);
         chk1("wr_ready low in wait", wr_ready, 1'b0);
      end
   endtask

   task automatic run_wait(input int dly, input logic [7:0] exp_end);
      for (int i = 0; i < dly; i++) begin
         tick();
         chk1("no job_done before sm_done", job_done, 1'b0);
      end
      sm_done = 1'b1;
      tick();
      chk1("job_done after sm_done rise", job_done, 1'b1);
      chk1("busy in fin", busy, 1'b1);
      tick();
      chk1("job_done single pulse", job_done, 1'b0);
      chk1("busy low after fin", busy, 1'b0);
      chk1("wr_ready back in idle", wr_ready, 1'b1);
      check("end_addr held", 64'(end_addr), 64'(exp_end));
      tick();
      sm_done = 1'b0;
   endtask

   initial begin
      int         cnt;
      bit         ovf;
      bit         has_last;
      int         n;
      logic [7:0] base;

      vecs[0] = '{8'd0,   4,  1'b1, 1'b0, 8'd4,   1'b0, 5};
      vecs[1] = '{8'd10,  3,  1'b1, 1'b1, 8'd13,  1'b0, 50};
      vecs[2] = '{8'd250, 10, 1'b0, 1'b0, 8'd255, 1'b1, 3};
      vecs[3] = '{8'd100, 1,  1'b1, 1'b0, 8'd101, 1'b0, 1};
      vecs[4] = '{8'd252, 2,  1'b1, 1'b0, 8'd254, 1'b0, 2};
      vecs[5] = '{8'd253, 2,  1'b1, 1'b0, 8'd255, 1'b1, 2};

      reset = 1'b1; wr_valid = 1'b0; wr_last = 1'b0; sm_done = 1'b0; wr_data = '0;
      base_addr = '0; addr = '0; sub0_inp_addr = '0; sub1_inp_addr = '0;
      tick();
      tick();
      check("outputs in reset", 64'({wr_ready, init, start, busy, job_done, err,
                                     start_addr, end_addr}), 64'd0);
      reset = 1'b0;
      tick();
      chk1("wr_ready after reset release", wr_ready, 1'b1);

      for (int v = 0; v < 6; v++) begin
         cnt = load_len(vecs[v].base, vecs[v].n, ovf);
         run_load(vecs[v].base, vecs[v].n, vecs[v].has_last, vecs[v].gaps, 1'b1,
                  vecs[v].exp_end, vecs[v].exp_err);
         run_reads(vecs[v].base, cnt);
         if (v == 0) begin
            addr = 8'd2;
            #1;
            check("basic word 2", inp, 64'h0009_000a_000b_000c);
         end
         run_wait(vecs[v].dly, vecs[v].exp_end);
      end

      // Timeout: no sm_done edge at all.
      run_load(8'd60, 2, 1'b1, 1'b0, 1'b0, 8'd62, 1'b0);
      for (int i = 1; i <= int'(Timeout) + 1; i++) begin
         tick();
         chk1("timeout job_done timing", job_done, i == int'(Timeout) + 1);
         chk1("timeout err timing", err, i == int'(Timeout) + 1);
      end
      tick();
      chk1("busy low after timeout", busy, 1'b0);
      chk1("err sticky in idle", err, 1'b1);

      // sm_done already high when WAIT is entered must not complete the job.
      run_load(8'd70, 1, 1'b1, 1'b0, 1'b0, 8'd71, 1'b0);
      sm_done = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk1("stale sm_done ignored", job_done, 1'b0);
      end
      sm_done = 1'b0;
      tick();
      chk1("still busy after stale done", busy, 1'b1);
      run_wait(1, 8'd71);

      // Reset in the middle of WAIT.
      run_load(8'd30, 3, 1'b1, 1'b0, 1'b0, 8'd33, 1'b0);
      tick();
      tick();
      reset   = 1'b1;
      sm_done = 1'b1;
      tick();
      check("outputs after mid-wait reset", 64'({wr_ready, init, start, busy, job_done, err,
                                                 start_addr, end_addr}), 64'd0);
      reset = 1'b0;
      chk1("wr_ready still low at release", wr_ready, 1'b0);
      tick();
      chk1("wr_ready after mid-wait reset", wr_ready, 1'b1);
      chk1("no job_done after reset", job_done, 1'b0);
      sm_done = 1'b0;
      for (int j = 0; j < 3; j++) begin
         addr = 8'd30 + 8'(j);
         tick();
         check("memory kept over reset", inp, mmem[addr]);
      end

      // Randomized jobs against the model.
      for (int r = 0; r < 12; r++) begin
         base     = 8'($urandom_range(0, 250));
         has_last = 1'b1;
         n        = int'($urandom_range(1, 8));
         if (base > 8'd240 && $urandom_range(0, 1) == 1) begin
            has_last = 1'b0;
            n        = 255 - int'(base) + 2;
         end
         cnt = load_len(base, n, ovf);
         run_load(base, n, has_last, 1'($urandom_range(0, 1)), 1'b0, base + 8'(cnt), ovf);
         run_reads(base, cnt);
         run_wait(int'($urandom_range(0, 30)), base + 8'(cnt));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
